// File: rtl/chip8_scanout_if.sv
// Bundles the beam inputs, the framebuffer read port and the video outputs
// of the CHIP-8 scanout block.
//   slave  : the scanout itself (consumes beam/syncs/fb_rdata, drives the rest)
//   master : the surrounding system (sync generator, framebuffer RAM, display)
interface chip8_scanout_if;
   logic [8:0] hpos;
   logic [8:0] vpos;
   logic       display_on;
   logic       hsync;
   logic       vsync;
   logic [7:0] fb_addr;
   logic       fb_rd_en;
   logic [7:0] fb_rdata;
   logic [2:0] rgb;
   logic       hsync_out;
   logic       vsync_out;
   logic       vblank_pulse;

   modport slave (
      input  hpos, vpos, display_on, hsync, vsync, fb_rdata,
      output fb_addr, fb_rd_en, rgb, hsync_out, vsync_out, vblank_pulse
   );

   modport master (
      output hpos, vpos, display_on, hsync, vsync, fb_rdata,
      input  fb_addr, fb_rd_en, rgb, hsync_out, vsync_out, vblank_pulse
   );
endinterface

// File: rtl/chip8_scanout.sv
// CHIP-8 display back end. Fetches the 64x32 1bpp framebuffer one byte per
// 8 pixels and scales every pixel 4x4 into a 256x128 window that is centred
// vertically in the 256x240 active area. Colour and syncs leave through a
// fixed 2-cycle pipeline; vblank_pulse marks each rising edge of vsync_out.
// Ports:
//   clk     : pixel clock, shared with the sync generator
//   reset_n : asynchronous active-low reset
//   bus     : beam position/syncs in, framebuffer read port, rgb/syncs out
module chip8_scanout #(
   parameter int unsigned V_OFFSET     = 56,
   parameter logic [2:0]  FG_COLOR     = 3'b111,
   parameter logic [2:0]  BG_COLOR     = 3'b000,
   parameter logic [2:0]  BORDER_COLOR = 3'b001
) (
   input  logic             clk,
   input  logic             reset_n,
   chip8_scanout_if.slave   bus
);

   localparam logic [8:0] C_V_LO = 9'(V_OFFSET);
   localparam logic [8:0] C_V_HI = 9'(V_OFFSET + 128);

   // stage 0: window decode and fetch request
   logic       w_in_win;
   logic [4:0] w_row;
   logic [7:0] w_addr_new;
   logic       w_rd_en;
   logic [7:0] r_addr_hold;

   // stage 1
   logic       r1_in_win;
   logic       r1_disp;
   logic [2:0] r1_idx;
   logic       r1_load;
   logic       r1_hs;
   logic       r1_vs;
   logic [7:0] r_byte_hold;
   logic [7:0] w_byte_cur;
   logic       w_pix;

   // stage 2
   logic [2:0] r_rgb;
   logic       r_hs_out;
   logic       r_vs_out;
   logic       r_vs_prev;
   logic       r_vblank;

   // Range compare happens on raw vpos, so the subtraction below never wraps
   // into the window from lines above V_OFFSET.
   assign w_in_win   = bus.display_on && !bus.hpos[8] &&
                       (bus.vpos >= C_V_LO) && (bus.vpos < C_V_HI);
   assign w_row      = 5'((bus.vpos - C_V_LO) >> 2);
   assign w_addr_new = {w_row, bus.hpos[7:5]};

   // Gated by reset so no read is issued while the pipeline is held clear.
   assign w_rd_en    = reset_n && w_in_win && (bus.hpos[4:0] == 5'd0);

   assign bus.fb_rd_en = w_rd_en;
   assign bus.fb_addr  = w_rd_en ? w_addr_new : r_addr_hold;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr_hold <= '0;
      end else if (w_rd_en) begin
         r_addr_hold <= w_addr_new;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r1_in_win <= 1'b0;
         r1_disp   <= 1'b0;
         r1_idx    <= '0;
         r1_load   <= 1'b0;
         r1_hs     <= 1'b0;
         r1_vs     <= 1'b0;
      end else begin
         r1_in_win <= w_in_win;
         r1_disp   <= bus.display_on;
         r1_idx    <= bus.hpos[4:2];
         r1_load   <= w_rd_en;
         r1_hs     <= bus.hsync;
         r1_vs     <= bus.vsync;
      end
   end

   // RAM data arrives one cycle after the strobe; it is used directly on that
   // cycle and kept for the remaining 31 pixels of the byte.
   assign w_byte_cur = r1_load ? bus.fb_rdata : r_byte_hold;
   assign w_pix      = w_byte_cur[3'd7 - r1_idx];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_byte_hold <= '0;
      end else begin
         r_byte_hold <= w_byte_cur;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rgb     <= '0;
         r_hs_out  <= 1'b0;
         r_vs_out  <= 1'b0;
         r_vs_prev <= 1'b0;
         r_vblank  <= 1'b0;
      end else begin
         if (!r1_disp) begin
            r_rgb <= '0;
         end else if (!r1_in_win) begin
            r_rgb <= BORDER_COLOR;
         end else if (w_pix) begin
            r_rgb <= FG_COLOR;
         end else begin
            r_rgb <= BG_COLOR;
         end
         r_hs_out  <= r1_hs;
         r_vs_out  <= r1_vs;
         r_vs_prev <= r_vs_out;
         r_vblank  <= r_vs_out && !r_vs_prev;
      end
   end

   assign bus.rgb          = r_rgb;
   assign bus.hsync_out    = r_hs_out;
   assign bus.vsync_out    = r_vs_out;
   assign bus.vblank_pulse = r_vblank;

endmodule

// File: tb/tb_chip8_scanout.sv
module tb_chip8_scanout;

   logic clk;
   logic reset_n;
   chip8_scanout_if bus();

   chip8_scanout dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // framebuffer RAM, synchronous read
   logic [7:0] mem [256];
   always @(posedge clk) begin
      if (bus.fb_rd_en) bus.fb_rdata <= mem[bus.fb_addr];
   end

   int total = 0;
   int bad   = 0;
   int n_rd  = 0;
   int n_vb  = 0;

   // reference model state
   int         last_byte = 0;
   int         last_addr = 0;
   logic [2:0] d1_rgb = 0;
   logic       d1_hs  = 0;
   logic       d1_vs  = 0;
   logic       vso_h1 = 0;
   logic       vso_h2 = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int h, input int v, input bit d, input bit hs,
                       input bit vs, input bit rst);
      int         e_rd;
      int         e_addr;
      logic [2:0] c_rgb;
      bit         in_win;
      int         pix;
      bus.hpos       = 9'(h);
      bus.vpos       = 9'(v);
      bus.display_on = d;
      bus.hsync      = hs;
      bus.vsync      = vs;
      reset_n        = !rst;
      if (rst) begin
         last_byte = 0;
         last_addr = 0;
         e_rd      = 0;
         e_addr    = 0;
         c_rgb     = 3'b000;
      end else begin
         in_win = d && (h < 256) && (v >= 56) && (v < 184);
         e_rd   = (in_win && (h % 32) == 0) ? 1 : 0;
         if (e_rd != 0) begin
            last_addr = ((v - 56) / 4) * 8 + (h / 32) % 8;
            last_byte = mem[last_addr];
         end
         e_addr = last_addr;
         pix    = (last_byte >> (7 - (h / 4) % 8)) & 1;
         if (!d)              c_rgb = 3'b000;
         else if (!in_win)    c_rgb = 3'b001;
         else if (pix != 0)   c_rgb = 3'b111;
         else                 c_rgb = 3'b000;
      end
      #1;
      chk("fb_rd_en", 32'(bus.fb_rd_en), 32'(e_rd));
      chk("fb_addr", 32'(bus.fb_addr), 32'(e_addr));
      if (bus.fb_rd_en === 1'b1) n_rd++;
      @(posedge clk);
      #1;
      if (rst) begin
         d1_rgb = 0; d1_hs = 0; d1_vs = 0; vso_h1 = 0; vso_h2 = 0;
      end
      chk("rgb", 32'(bus.rgb), 32'(d1_rgb));
      chk("hsync_out", 32'(bus.hsync_out), 32'(d1_hs));
      chk("vsync_out", 32'(bus.vsync_out), 32'(d1_vs));
      chk("vblank_pulse", 32'(bus.vblank_pulse), 32'(vso_h1 && !vso_h2));
      if (bus.vblank_pulse === 1'b1) n_vb++;
      vso_h2 = vso_h1;
      vso_h1 = d1_vs;
      d1_rgb = c_rgb;
      d1_hs  = rst ? 1'b0 : hs;
      d1_vs  = rst ? 1'b0 : vs;
   endtask

   initial begin
      reset_n        = 1'b0;
      bus.hpos       = '0;
      bus.vpos       = '0;
      bus.display_on = 1'b0;
      bus.hsync      = 1'b0;
      bus.vsync      = 1'b0;
      bus.fb_rdata   = '0;
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      @(posedge clk);
      #1;

      // reset held with random inputs
      for (int i = 0; i < 8; i++)
         step($urandom_range(0, 300), $urandom_range(0, 260), 1'($urandom),
              1'($urandom), 1'($urandom), 1'b1);

      // pixel path: single lit pixel at top-left
      mem[0] = 8'h80;
      for (int h = 0; h < 40; h++) step(h, 56, 1'b1, 1'b0, 1'b0, 1'b0);

      // addressing corners and window edges
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int h = 224; h < 232; h++) step(h, 183, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int h = 0; h < 6; h++) step(h, 184, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int h = 0; h < 6; h++) step(h, 55, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int h = 256; h < 262; h++) step(h, 100, 1'b0, 1'b1, 1'b0, 1'b0);

      // mid-line reset on an all-ones frame
      for (int i = 0; i < 256; i++) mem[i] = 8'hFF;
      for (int h = 0; h < 48; h++)
         step(h, 60, 1'b1, 1'b0, 1'b0, (h >= 10 && h < 20));

      // random beam jumps, syncs and occasional resets
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 600; i++)
         step($urandom_range(0, 300), $urandom_range(0, 260), 1'($urandom),
              1'($urandom), 1'($urandom), ($urandom_range(0, 49) == 0));
      for (int i = 0; i < 4; i++) step(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

      // full frame against the reference scan
      n_rd = 0;
      n_vb = 0;
      for (int v = 0; v < 244; v++)
         for (int h = 0; h < 264; h++)
            step(h, v, (h < 256 && v < 240), (h >= 258 && h < 262),
                 (v == 241 || v == 242), 1'b0);
      chk("reads_per_frame", 32'(n_rd), 32'd1024);
      chk("vblank_per_frame", 32'(n_vb), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
